qhv_scheduler: RTL and testbench

QHV_SCHEDULER -- requirements
Module: qhv_scheduler

---
 rtl/qhv_scheduler.sv | 134 +++++++++++++
 tb/tb_qhv_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/qhv_scheduler.sv
// Round-robin arbiter that feeds query hypervectors to the associative memory
// and routes each AM result back to the requester that issued the query.
module qhv_scheduler #(
  parameter int unsigned HVDimension = 512,
  parameter int unsigned NumReq      = 4,
  parameter int unsigned ResWidth    = 32,
  parameter int unsigned CntWidth    = 16,
  localparam int unsigned IdWidth    = $clog2(NumReq)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clr_i,
  input  logic [NumReq-1:0][HVDimension-1:0]  req_hv_i,
  input  logic [NumReq-1:0]                   req_valid_i,
  output logic [NumReq-1:0]                   req_ready_o,
  output logic [HVDimension-1:0]              qhv_o,
  output logic                                qhv_wen_o,
  output logic                                qhv_am_load_o,
  output logic                                qhv_clr_o,
  input  logic                                qhv_valid_i,
  input  logic [ResWidth-1:0]                 res_data_i,
  input  logic                                res_valid_i,
  output logic                                res_ready_o,
  output logic [ResWidth-1:0]                 rsp_data_o,
  output logic [NumReq-1:0]                   rsp_valid_o,
  input  logic [NumReq-1:0]                   rsp_ready_i,
  output logic                                busy_o,
  output logic [IdWidth-1:0]                  owner_o,
  output logic [CntWidth-1:0]                 query_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_AM  = 2'd1,
    WAIT_RES = 2'd2
  } state_e;

  localparam logic [IdWidth:0]   NumReqW = (IdWidth+1)'(NumReq);
  localparam logic [IdWidth-1:0] LastId  = IdWidth'(NumReq - 1);

  state_e             state_q, state_d;
  logic [IdWidth-1:0] ptr_q, ptr_d;
  logic [IdWidth-1:0] owner_q, owner_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  logic               grant_vld;
  logic [IdWidth-1:0] grant_id;
  logic [IdWidth:0]   idx;
  logic               grant;
  logic               res_live;
  logic               res_hs;

  // First valid requester at or after ptr, wrapping modulo NumReq.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int i = 0; i < NumReq; i++) begin
      idx = {1'b0, ptr_q} + (IdWidth+1)'(i);
      if (idx >= NumReqW) idx = idx - NumReqW;
      if (!grant_vld && req_valid_i[idx[IdWidth-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = idx[IdWidth-1:0];
      end
    end
  end

  assign grant    = (state_q == IDLE) && !rst_i && !clr_i && grant_vld;
  assign res_live = (state_q == WAIT_RES) && !rst_i && !clr_i;
  assign res_hs   = res_valid_i && res_ready_o;

  always_comb begin
    req_ready_o           = '0;
    req_ready_o[grant_id] = grant;
    qhv_o                 = grant ? req_hv_i[grant_id] : '0;
    qhv_wen_o             = grant;
    qhv_am_load_o         = grant;
    qhv_clr_o             = clr_i;
    rsp_data_o            = res_data_i;
    rsp_valid_o           = '0;
    rsp_valid_o[owner_q]  = res_live && res_valid_i;
    res_ready_o           = res_live && rsp_ready_i[owner_q];
    busy_o                = !rst_i && (state_q != IDLE);
    owner_o               = rst_i ? '0 : owner_q;
    query_cnt_o           = rst_i ? '0 : cnt_q;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      state_d = IDLE;
      ptr_d   = '0;
      owner_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            state_d = WAIT_AM;
            owner_d = grant_id;
            ptr_d   = (grant_id == LastId) ? '0 : grant_id + 1'b1;
          end
        end
        WAIT_AM: begin
          if (!qhv_valid_i) state_d = WAIT_RES;
        end
        WAIT_RES: begin
          if (res_hs) begin
            state_d = IDLE;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_qhv_scheduler.sv
// Directed vector bench for qhv_scheduler: one table row per clock cycle,
// followed by a hand-driven query with a bounded wait on the result.
module tb_qhv_scheduler;

  localparam int unsigned HV  = 8;
  localparam int unsigned NR  = 4;
  localparam int unsigned RW  = 8;
  localparam int unsigned CW  = 2;

  logic                   clk;
  logic                   rst;
  logic                   clr;
  logic [NR-1:0][HV-1:0]  req_hv;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0]          req_ready;
  logic [HV-1:0]          qhv;
  logic                   qhv_wen;
  logic                   qhv_am_load;
  logic                   qhv_clr;
  logic                   qhv_valid;
  logic [RW-1:0]          res_data;
  logic                   res_valid;
  logic                   res_ready;
  logic [RW-1:0]          rsp_data;
  logic [NR-1:0]          rsp_valid;
  logic [NR-1:0]          rsp_ready;
  logic                   busy;
  logic [1:0]             owner;
  logic [CW-1:0]          query_cnt;

  qhv_scheduler #(
    .HVDimension(HV),
    .NumReq     (NR),
    .ResWidth   (RW),
    .CntWidth   (CW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clr_i        (clr),
    .req_hv_i     (req_hv),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .qhv_o        (qhv),
    .qhv_wen_o    (qhv_wen),
    .qhv_am_load_o(qhv_am_load),
    .qhv_clr_o    (qhv_clr),
    .qhv_valid_i  (qhv_valid),
    .res_data_i   (res_data),
    .res_valid_i  (res_valid),
    .res_ready_o  (res_ready),
    .rsp_data_o   (rsp_data),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .busy_o       (busy),
    .owner_o      (owner),
    .query_cnt_o  (query_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       clr;
    logic [3:0] rv;
    logic       qv;
    logic       rsv;
    logic [3:0] rr;
    logic [3:0] e_rdy;
    logic       e_wen;
    logic       e_qclr;
    logic       e_resrdy;
    logic [3:0] e_rspv;
    logic       e_busy;
    logic [1:0] e_own;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t vq[$];
  int   n_chk;
  int   n_pass;

  function automatic vec_t mk(
    input logic r, input logic c, input logic [3:0] rv,
    input logic qv, input logic rsv, input logic [3:0] rr,
    input logic [3:0] e_rdy, input logic e_wen, input logic e_qclr,
    input logic e_resrdy, input logic [3:0] e_rspv, input logic e_busy,
    input logic [1:0] e_own, input logic [1:0] e_cnt);
    vec_t v;
    v.rst = r; v.clr = c; v.rv = rv; v.qv = qv; v.rsv = rsv; v.rr = rr;
    v.e_rdy = e_rdy; v.e_wen = e_wen; v.e_qclr = e_qclr;
    v.e_resrdy = e_resrdy; v.e_rspv = e_rspv; v.e_busy = e_busy;
    v.e_own = e_own; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  initial begin
    logic [16:0] act;
    logic [16:0] exp;
    logic [HV-1:0] exp_hv;
    logic got_rsp;

    n_chk = 0;
    n_pass = 0;
    for (int i = 0; i < NR; i++) req_hv[i] = HV'(8'hA0 + i);
    rst = 1'b1; clr = 1'b0; req_valid = '0; qhv_valid = 1'b0;
    res_valid = 1'b0; res_data = '0; rsp_ready = '0;
    repeat (2) @(negedge clk);

    //        rst clr rv     qv rsv rr      rdy    wen qc rr  rspv   bsy own cnt
    vq.push_back(mk(1,0,4'b0000,0,0,4'b0000, 4'b0000,0,0,0,4'b0000,0,0,0));
    vq.push_back(mk(0,0,4'b0100,0,0,4'b0000, 4'b0100,1,0,0,4'b0000,0,0,0));
    vq.push_back(mk(0,0,4'b0000,1,0,4'b0000, 4'b0000,0,0,0,4'b0000,1,2,0));
    vq.push_back(mk(0,0,4'b0000,1,0,4'b0000, 4'b0000,0,0,0,4'b0000,1,2,0));
    vq.push_back(mk(0,0,4'b0000,1,0,4'b0000, 4'b0000,0,0,0,4'b0000,1,2,0));
    vq.push_back(mk(0,0,4'b0000,0,1,4'b1111, 4'b0000,0,0,0,4'b0000,1,2,0));
    vq.push_back(mk(0,0,4'b0000,0,1,4'b1111, 4'b0000,0,0,1,4'b0100,1,2,0));
    vq.push_back(mk(0,0,4'b0000,0,0,4'b0000, 4'b0000,0,0,0,4'b0000,0,2,1));
    vq.push_back(mk(0,0,4'b0001,0,0,4'b0000, 4'b0001,1,0,0,4'b0000,0,2,1));
    vq.push_back(mk(0,0,4'b0001,1,1,4'b1111, 4'b0000,0,0,0,4'b0000,1,0,1));
    vq.push_back(mk(0,0,4'b0000,0,1,4'b1111, 4'b0000,0,0,0,4'b0000,1,0,1));
    for (int k = 0; k < 5; k++)
      vq.push_back(mk(0,0,4'b0000,0,1,4'b1110, 4'b0000,0,0,0,4'b0001,1,0,1));
    vq.push_back(mk(0,0,4'b0000,0,1,4'b0001, 4'b0000,0,0,1,4'b0001,1,0,1));
    vq.push_back(mk(0,0,4'b0000,0,0,4'b0000, 4'b0000,0,0,0,4'b0000,0,0,2));
    vq.push_back(mk(0,0,4'b0010,0,0,4'b0000, 4'b0010,1,0,0,4'b0000,0,0,2));
    vq.push_back(mk(0,0,4'b1000,1,0,4'b0000, 4'b0000,0,0,0,4'b0000,1,1,2));
    vq.push_back(mk(0,1,4'b1000,1,0,4'b0000, 4'b0000,0,1,0,4'b0000,1,1,2));
    vq.push_back(mk(0,0,4'b1000,0,0,4'b0000, 4'b1000,1,0,0,4'b0000,0,0,2));
    vq.push_back(mk(0,0,4'b0000,0,0,4'b0000, 4'b0000,0,0,0,4'b0000,1,3,2));
    vq.push_back(mk(0,0,4'b0000,0,1,4'b1000, 4'b0000,0,0,1,4'b1000,1,3,2));
    vq.push_back(mk(0,0,4'b0000,0,0,4'b0000, 4'b0000,0,0,0,4'b0000,0,3,3));
    vq.push_back(mk(0,1,4'b0001,0,0,4'b0000, 4'b0000,0,1,0,4'b0000,0,3,3));
    vq.push_back(mk(0,0,4'b0001,0,0,4'b0000, 4'b0001,1,0,0,4'b0000,0,0,3));
    vq.push_back(mk(0,0,4'b0000,0,0,4'b0000, 4'b0000,0,0,0,4'b0000,1,0,3));
    vq.push_back(mk(0,1,4'b0000,0,1,4'b0001, 4'b0000,0,1,0,4'b0000,1,0,3));
    vq.push_back(mk(0,0,4'b0000,0,0,4'b0000, 4'b0000,0,0,0,4'b0000,0,0,3));
    // all four requesting, AM consumes and answers at once
    vq.push_back(mk(0,0,4'b1111,0,0,4'b0000, 4'b0001,1,0,0,4'b0000,0,0,3));
    vq.push_back(mk(0,0,4'b1111,0,0,4'b0000, 4'b0000,0,0,0,4'b0000,1,0,3));
    vq.push_back(mk(0,0,4'b1111,0,1,4'b1111, 4'b0000,0,0,1,4'b0001,1,0,3));
    vq.push_back(mk(0,0,4'b1111,0,0,4'b0000, 4'b0010,1,0,0,4'b0000,0,0,0));
    vq.push_back(mk(0,0,4'b1111,0,0,4'b0000, 4'b0000,0,0,0,4'b0000,1,1,0));
    vq.push_back(mk(0,0,4'b1111,0,1,4'b1111, 4'b0000,0,0,1,4'b0010,1,1,0));
    vq.push_back(mk(0,0,4'b1111,0,0,4'b0000, 4'b0100,1,0,0,4'b0000,0,1,1));
    vq.push_back(mk(0,0,4'b1111,0,0,4'b0000, 4'b0000,0,0,0,4'b0000,1,2,1));
    vq.push_back(mk(0,0,4'b1111,0,1,4'b1111, 4'b0000,0,0,1,4'b0100,1,2,1));
    vq.push_back(mk(0,0,4'b1111,0,0,4'b0000, 4'b1000,1,0,0,4'b0000,0,2,2));
    vq.push_back(mk(0,0,4'b1111,0,0,4'b0000, 4'b0000,0,0,0,4'b0000,1,3,2));
    vq.push_back(mk(0,0,4'b1111,0,1,4'b1111, 4'b0000,0,0,1,4'b1000,1,3,2));
    vq.push_back(mk(0,0,4'b1111,0,0,4'b0000, 4'b0001,1,0,0,4'b0000,0,3,3));
    vq.push_back(mk(0,0,4'b1111,0,0,4'b0000, 4'b0000,0,0,0,4'b0000,1,0,3));
    vq.push_back(mk(0,0,4'b1111,0,1,4'b1111, 4'b0000,0,0,1,4'b0001,1,0,3));
    vq.push_back(mk(0,0,4'b0000,0,0,4'b0000, 4'b0000,0,0,0,4'b0000,0,0,0));
    // reset abandons a query sitting in WAIT_RES
    vq.push_back(mk(0,0,4'b0010,0,0,4'b0000, 4'b0010,1,0,0,4'b0000,0,0,0));
    vq.push_back(mk(0,0,4'b0000,0,0,4'b0000, 4'b0000,0,0,0,4'b0000,1,1,0));
    vq.push_back(mk(0,0,4'b0000,0,1,4'b1111, 4'b0000,0,0,1,4'b0010,1,1,0));
    vq.push_back(mk(0,0,4'b0100,0,0,4'b0000, 4'b0100,1,0,0,4'b0000,0,1,1));
    vq.push_back(mk(0,0,4'b0000,0,0,4'b0000, 4'b0000,0,0,0,4'b0000,1,2,1));
    vq.push_back(mk(1,0,4'b0000,0,1,4'b1111, 4'b0000,0,0,0,4'b0000,0,0,0));
    vq.push_back(mk(0,0,4'b0000,0,0,4'b0000, 4'b0000,0,0,0,4'b0000,0,0,0));
    vq.push_back(mk(0,0,4'b1111,0,0,4'b0000, 4'b0001,1,0,0,4'b0000,0,0,0));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst       = vq[i].rst;
      clr       = vq[i].clr;
      req_valid = vq[i].rv;
      qhv_valid = vq[i].qv;
      res_valid = vq[i].rsv;
      rsp_ready = vq[i].rr;
      res_data  = RW'(8'h50 + i);
      #1;
      act = {req_ready, qhv_wen, qhv_am_load, qhv_clr, res_ready,
             rsp_valid, busy, owner, query_cnt};
      exp = {vq[i].e_rdy, vq[i].e_wen, vq[i].e_wen, vq[i].e_qclr,
             vq[i].e_resrdy, vq[i].e_rspv, vq[i].e_busy, vq[i].e_own,
             vq[i].e_cnt};
      check($sformatf("vec%0d outputs", i), 32'(act), 32'(exp));
      check($sformatf("vec%0d rsp_data", i), 32'(rsp_data),
            32'(RW'(8'h50 + i)));
      if (vq[i].e_wen) begin
        exp_hv = '0;
        for (int b = 0; b < NR; b++)
          if (vq[i].e_rdy[b]) exp_hv = HV'(8'hA0 + b);
        check($sformatf("vec%0d qhv", i), 32'(qhv), 32'(exp_hv));
      end
    end

    // Requester 0 was just granted: AM holds the query two cycles,
    // then a result arrives and must reach requester 0 within the budget.
    @(negedge clk);
    req_valid = '0; qhv_valid = 1'b1; res_valid = 1'b0; rsp_ready = '0;
    @(negedge clk);
    @(negedge clk);
    qhv_valid = 1'b0; res_valid = 1'b1; rsp_ready = 4'b1111;
    res_data = 8'hC3;
    got_rsp = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (rsp_valid == 4'b0001 && res_ready) begin
        got_rsp = 1'b1;
        check("seq rsp_data", 32'(rsp_data), 32'h0000_00C3);
        break;
      end
      @(negedge clk);
    end
    check("seq result delivered", 32'(got_rsp), 32'd1);
    @(negedge clk);
    res_valid = 1'b0; rsp_ready = '0;
    #1;
    check("seq idle cnt", 32'({busy, query_cnt}), 32'({1'b0, 2'd1}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
